// File: rtl/vga_board_capture.sv
// vga_board_capture
// Receive side of the Game-of-Life VGA link. Recovers the pixel position from
// the hsync/vsync edges of the tiny-vga pin bundle, samples the centre pixel
// of every board cell and publishes the rebuilt board once per full frame,
// together with change tracking, a generation counter and a colour sanity flag.
module vga_board_capture #(
    parameter int H_SYNC    = 96,   // hsync pulse width in pixel clocks
    parameter int H_BACK    = 48,   // horizontal back porch
    parameter int V_SYNC    = 2,    // vsync pulse width in lines
    parameter int V_BACK    = 33,   // vertical back porch
    parameter int H_VIS     = 640,  // visible pixels per line
    parameter int V_VIS     = 480,  // visible lines
    parameter int CELL      = 48,   // cell edge in pixels
    parameter int BOARD_DIM = 8,    // cells per side
    parameter bit SYNC_POL  = 1'b0  // active level of hsync/vsync
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     vga_in,      // {hs, b0, g0, r0, vs, b1, g1, r1}
    input  logic                           capture_en,
    output logic [BOARD_DIM*BOARD_DIM-1:0] board,       // bit index = row*BOARD_DIM + col
    output logic                           frame_valid,
    output logic                           changed,
    output logic [15:0]                    gen_count,
    output logic                           bad_pixel,
    output logic                           locked
);

    localparam int NCELL  = BOARD_DIM * BOARD_DIM;
    localparam int CNT_W  = $clog2(NCELL + 1);
    localparam int SIDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;

    // Top-left corner of the board inside the visible area (board is centred).
    localparam int X0 = (H_VIS - CELL * BOARD_DIM) / 2;
    localparam int Y0 = (V_VIS - CELL * BOARD_DIM) / 2;

    // Counter values at which the centre of column 0 / row 0 is on the wire.
    localparam int H_FIRST = H_SYNC + H_BACK + X0 + CELL / 2;
    localparam int V_FIRST = V_SYNC + V_BACK + Y0 + CELL / 2;

    localparam logic [9:0]       CNT_MAX = 10'd1023;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(NCELL);

    // HUNT: waiting for a vsync edge to frame the next capture.
    // TRACK: counters are referenced to a vsync edge and cells are sampled.
    typedef enum logic {
        ST_HUNT,
        ST_TRACK
    } state_t;

    state_t state, state_nx;

    logic [7:0]             d, dp;
    logic                   hs_edge, vs_edge;
    logic [9:0]             hcnt, vcnt;
    logic                   sat;
    logic                   col_hit, row_hit;
    logic [SIDX_W-1:0]      col_idx, row_base, sample_idx;
    logic [5:0]             pix;
    logic                   alive, mixed;
    logic                   sample_en, publish;
    logic [NCELL-1:0]       shadow;
    logic                   shadow_bad;
    logic [CNT_W-1:0]       sample_cnt;
    logic                   published;

    // Input pipeline: one register stage plus the previous value for edge detect.
    // NOTE: state is updated with <= so every register sees pre-edge values,
    // regardless of the order the always_ff blocks happen to be evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d  <= '0;
            dp <= '0;
        end else begin
            d  <= vga_in;
            dp <= d;
        end
    end

    // A sync edge is the transition from the inactive to the active level.
    assign hs_edge = (dp[7] != SYNC_POL) && (d[7] == SYNC_POL);
    assign vs_edge = (dp[3] != SYNC_POL) && (d[3] == SYNC_POL);

    // Horizontal position: restarts at each hsync edge, saturates when hsync is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
        end else if (hs_edge) begin
            hcnt <= '0;
        end else if (hcnt != CNT_MAX) begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Vertical position: vsync clears it (winning over the coincident hsync edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt <= '0;
        end else if (vs_edge) begin
            vcnt <= '0;
        end else if (hs_edge && (vcnt != CNT_MAX)) begin
            vcnt <= vcnt + 10'd1;
        end
    end

    // A saturated counter means the sync timing is no longer being tracked.
    assign sat = (hcnt == CNT_MAX) || (vcnt == CNT_MAX);

    // Cell-centre comparators: one per column and one per row, no division needed.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        col_hit  = 1'b0;
        col_idx  = '0;
        row_hit  = 1'b0;
        row_base = '0;
        for (int c = 0; c < BOARD_DIM; c++) begin
            if (hcnt == 10'(H_FIRST + CELL * c)) begin
                col_hit = 1'b1;
                col_idx = SIDX_W'(c);
            end
        end
        for (int r = 0; r < BOARD_DIM; r++) begin
            if (vcnt == 10'(V_FIRST + CELL * r)) begin
                row_hit  = 1'b1;
                row_base = SIDX_W'(r * BOARD_DIM);
            end
        end
    end

    assign sample_idx = row_base + col_idx;

    // Colour decode: black = live cell, white = dead cell, anything else is bad.
    assign pix   = {d[6:4], d[2:0]};
    assign alive = (pix == 6'h00);
    assign mixed = (pix != 6'h00) && (pix != 6'h3f);

    // Acquisition FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nx;
        end
    end

    // Acquisition FSM next state plus the sample/publish strobes it qualifies.
    always_comb begin
        state_nx  = state;
        sample_en = 1'b0;
        publish   = 1'b0;
        case (state)
            ST_HUNT: begin
                if (vs_edge && !sat) begin
                    state_nx = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (sat) begin
                    state_nx = ST_HUNT;
                end else begin
                    sample_en = col_hit && row_hit;
                    publish   = vs_edge && capture_en && (sample_cnt == FULL);
                end
            end
            default: state_nx = ST_HUNT;
        endcase
    end

    // Shadow board: collects one sample per cell between two vsync edges.
    // NOTE: the shadow board is a flop vector with a defined reset value, not a
    // RAM, so resetting it is both legal and required for a zero start state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            shadow_bad <= 1'b0;
            sample_cnt <= '0;
        end else if (vs_edge) begin
            sample_cnt <= '0;
            shadow_bad <= 1'b0;
        end else if (sat) begin
            sample_cnt <= '0;
        end else if (sample_en) begin
            shadow[sample_idx] <= alive;
            if (sample_cnt != '1) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (mixed) begin
                shadow_bad <= 1'b1;
            end
        end
    end

    // Published outputs: updated only on a full-frame publish, lock dropped on saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board       <= '0;
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            gen_count   <= '0;
            bad_pixel   <= 1'b0;
            locked      <= 1'b0;
            published   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (publish) begin
                board       <= shadow;
                changed     <= (shadow != board);
                bad_pixel   <= shadow_bad;
                frame_valid <= 1'b1;
                locked      <= 1'b1;
                published   <= 1'b1;
                // The very first publish after reset is a baseline, not a generation.
                if ((shadow != board) && published) begin
                    gen_count <= gen_count + 16'd1;
                end
            end else if (sat) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vga_board_capture.md
Name: vga_board_capture

Overview:
Receive-side counterpart of the Game-of-Life VGA output. It takes the tiny-vga pin bundle, which carries the syncs plus 2-bit RGB, and recovers pixel position from the sync edges. It samples the centre pixel of each of the 8x8 board cells and publishes the reconstructed board once per frame. It also reports change and generation count. It sits on the ui/uio side for loopback self-test, and in the verification bench as the display scoreboard.

Parameters:
H_SYNC, 96, hsync pulse width in pixel clocks
H_BACK, 48, horizontal back porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
H_VIS, 640, visible pixels per line
V_VIS, 480, visible lines
CELL, 48, cell edge in pixels
BOARD_DIM, 8, cells per side (board has BOARD_DIM*BOARD_DIM bits)
SYNC_POL, 0, active level of hsync/vsync (0 = active low)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
vga_in  in  8  {hsync, b0, g0, r0, vsync, b1, g1, r1}
capture_en  in  1  1 = publish frames; 0 = hold outputs
board  out  64  recovered board, bit index = row*8 + col
frame_valid  out  1  one-clock pulse when board updated
changed  out  1  last published board differs from the one before
gen_count  out  16  number of published frames with changed=1
bad_pixel  out  1  last published frame had a non-black/non-white sample
locked  out  1  sync timing currently tracked

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values: all outputs are 0, all counters are 0, and the shadow board is 0.
- Input register: vga_in is registered one stage; all logic uses the registered copy (d) and its previous value (dp).
- Sync edges:
  - hs_edge = hsync(dp) inactive and hsync(d) active.
  - vs_edge = the same rule applied to vsync.
- hcnt (10 bit):
  - Set to 0 on hs_edge; otherwise increments.
  - Saturates at 1023.
  - Pixel x = hcnt - (H_SYNC + H_BACK).
- vcnt (10 bit):
  - Cleared on vs_edge, which has priority over hs_edge.
  - Increments on hs_edge; saturates at 1023.
  - Line y = vcnt - (V_SYNC + V_BACK).
  - A ±1 line offset from vsync phase is tolerated because samples sit at cell centres.
- Sample points:
  - X0 = (H_VIS - CELL*BOARD_DIM)/2 = 128; Y0 = (V_VIS - CELL*BOARD_DIM)/2 = 48.
  - Columns: x = X0 + CELL*c + CELL/2, i.e. 152, 200, ..., 488.
  - Rows: y = Y0 + CELL*r + CELL/2, i.e. 72, 120, ..., 408.
  - Implement with cell sub-counters or comparators; no dividers.
- Sample decode:
  - alive iff bits {6,5,4,2,1,0} are all 0.
  - dead iff those bits are all 1.
  - Anything else is dead and sets the shadow bad flag.
  - Each sample writes shadow[r*8+c] and increments a 7-bit sample count.
- Publish, evaluated on vs_edge:
  - If sample count == 64 and capture_en = 1, then on the next clock:
    - board <= shadow
    - changed <= (shadow != board)
    - bad_pixel <= shadow bad flag
    - gen_count += 1 (wraps) if changed and at least one frame was already published since reset
    - frame_valid pulses high for exactly 1 clock
    - locked <= 1
  - The sample count and shadow bad flag are cleared on every vs_edge, published or not.
- Partial frame:
  - The first vs_edge after reset or after loss of lock has count < 64, so no publish.
  - Outputs are held.
- Loss of lock:
  - hcnt or vcnt reaching saturation sets locked to 0 and zeroes the sample count.
  - board, changed and gen_count are held.
  - Relock occurs at the next full-frame publish.
- capture_en = 0: sampling continues, but publishes are suppressed. All outputs are held and frame_valid stays 0.
- Reset mid-frame: everything returns to its reset value immediately. The next publish needs one full frame framed by two vs_edges.

Test Plan:
1. Assert rst_n=0 mid-line with sync active -> all outputs 0 asynchronously; after release, the first vs_edge gives no frame_valid.
2. Drive standard 800x525 timing with cells 3, 6, 19, 22, 35, 38, 52, 53 black and the rest white -> at the second vs_edge, frame_valid = 1 for one clock, board = 64'h0030_0048_0048_0048, changed=1, gen_count=0.
3. Repeat the identical frame -> frame_valid pulses, changed=0, gen_count=0. Next frame with cell 3 white -> changed=1, gen_count=1, board bit 3 = 0.
4. Drive the centre pixel of cell 0 as border colour 110100 -> board[0]=0 and bad_pixel=1 on that publish; the following clean frame gives bad_pixel=0.
5. Suppress hsync for 1100 clocks mid-frame -> locked=0, no frame_valid at the next vs_edge; after one full clean frame -> frame_valid with locked=1.
6. Hold capture_en=0 for 3 frames with a changing pattern -> frame_valid stays 0 and board is unchanged; raise capture_en -> the next full frame publishes.
